// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Supports an optional grant lock and routes 1-cycle-latency read data back to its requester.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rw_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_R0   = 2'b01,
    LOCK_R1   = 2'b10
  } lock_e;

  lock_e             lock_q, lock_d;
  logic              ptr_q, ptr_d;        // requester favoured when both request
  logic              granted;
  logic              win;                 // 0 = requester 0, 1 = requester 1
  logic              win_we, win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [ADDR_W-1:0] addr_shadow;
  logic [DATA_W-1:0] wdata_shadow;
  logic              pend_valid, pend_id;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Grant is gated by rst_n so no access can be issued while reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    granted = 1'b0;
    win     = 1'b0;
    if (rst_n) begin
      if (lock_q == LOCK_R0 && req0) begin
        granted = 1'b1;
        win     = 1'b0;
      end else if (lock_q == LOCK_R1 && req1) begin
        granted = 1'b1;
        win     = 1'b1;
      end else if (req0 && req1) begin
        granted = 1'b1;
        win     = ptr_q;
      end else if (req0) begin
        granted = 1'b1;
        win     = 1'b0;
      end else if (req1) begin
        granted = 1'b1;
        win     = 1'b1;
      end
    end
  end

  assign win_we    = win ? we1    : we0;
  assign win_lock  = win ? lock1  : lock0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  assign gnt0 = granted && !win;
  assign gnt1 = granted &&  win;

  // Idle cycles present a harmless read at the last granted address/data.
  assign mem_rw_select = granted && win_we;
  assign mem_address   = granted ? win_addr  : addr_shadow;
  assign mem_data_in   = granted ? win_wdata : wdata_shadow;

  // A lock owner that drops req loses the lock on this edge as well.
  always_comb begin
    ptr_d  = ptr_q;
    lock_d = LOCK_NONE;
    if (granted) begin
      ptr_d = !win;
      if (win_lock) lock_d = win ? LOCK_R1 : LOCK_R0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= 1'b0;
      lock_q       <= LOCK_NONE;
      pend_valid   <= 1'b0;
      pend_id      <= 1'b0;
      addr_shadow  <= '0;
      wdata_shadow <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      pend_valid <= granted && !win_we;
      pend_id    <= win;
      if (granted) begin
        addr_shadow  <= win_addr;
        wdata_shadow <= win_wdata;
      end
      if (rvalid0) rdata0_q <= mem_data_out;
      if (rvalid1) rdata1_q <= mem_data_out;
    end
  end

  assign rvalid0 = pend_valid && !pend_id;
  assign rvalid1 = pend_valid &&  pend_id;

  // Read data is passed straight through in the return cycle and held afterwards.
  assign rdata0 = rvalid0 ? mem_data_out : rdata0_q;
  assign rdata1 = rvalid1 ? mem_data_out : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, reference memory and a read-return scoreboard.
module tb_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic mem_rw_select;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out = '0;

  logic [DATA_W-1:0] ram [512] = '{default: 8'h00};
  int ram_writes = 0;

  logic [DATA_W-1:0] exp_mem [512] = '{default: 8'h00};
  logic [DATA_W-1:0] exp_rdata0 = '0, exp_rdata1 = '0;
  logic [ADDR_W-1:0] shadow_addr = '0;
  logic [DATA_W-1:0] shadow_data = '0;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural 512x8 RAM with registered read data.
  always @(posedge clk) begin
    if (mem_rw_select) begin
      ram[mem_address] <= mem_data_in;
      ram_writes <= ram_writes + 1;
    end else begin
      mem_data_out <= ram[mem_address];
    end
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_rw_select(mem_rw_select), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  task automatic drop_inputs();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic clear_model();
    sb.delete();
    exp_rdata0 = '0;
    exp_rdata1 = '0;
    shadow_addr = '0;
    shadow_data = '0;
  endtask

  // Leaves time just after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 0;
    drop_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; checks read return, grant and RAM drive at the falling edge.
  task automatic step(input logic r0, input logic w0, input logic l0,
                      input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic [1:0] exp_gnt, input string name);
    rd_exp_t e;
    logic ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    @(negedge clk);

    checks++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (rvalid0 !== !e.id || rvalid1 !== e.id) begin
        failures++;
        $display("FAIL %s rvalid: got rv1/rv0=%b%b exp %b%b", name, rvalid1, rvalid0, e.id, !e.id);
      end
      if (e.id) exp_rdata1 = e.data;
      else      exp_rdata0 = e.data;
    end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      failures++;
      $display("FAIL %s rvalid: got rv1/rv0=%b%b exp 00", name, rvalid1, rvalid0);
    end

    checks++;
    if (rdata0 !== exp_rdata0 || rdata1 !== exp_rdata1) begin
      failures++;
      $display("FAIL %s rdata: got rd0=%h rd1=%h exp rd0=%h rd1=%h",
               name, rdata0, rdata1, exp_rdata0, exp_rdata1);
    end

    checks++;
    if ({gnt1, gnt0} !== exp_gnt) begin
      failures++;
      $display("FAIL %s gnt: got gnt1/gnt0=%b%b exp %b", name, gnt1, gnt0, exp_gnt);
    end

    case (exp_gnt)
      2'b01:   begin ew = w0; ea = a0; ed = d0; end
      2'b10:   begin ew = w1; ea = a1; ed = d1; end
      default: begin ew = 1'b0; ea = shadow_addr; ed = shadow_data; end
    endcase
    checks++;
    if (mem_rw_select !== ew || mem_address !== ea || mem_data_in !== ed) begin
      failures++;
      $display("FAIL %s mem drive: got rw=%b addr=%h din=%h exp rw=%b addr=%h din=%h",
               name, mem_rw_select, mem_address, mem_data_in, ew, ea, ed);
    end

    if (exp_gnt != 2'b00) begin
      shadow_addr = ea;
      shadow_data = ed;
      if (ew) exp_mem[ea] = ed;
      else begin
        e.id = exp_gnt[1];
        e.data = exp_mem[ea];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 2'b00, name);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_rw_select} !== 5'b0 ||
        rdata0 !== '0 || rdata1 !== '0 || mem_address !== '0 || mem_data_in !== '0) begin
      failures++;
      $display("FAIL %s: got gnt=%b%b rv=%b%b rd0=%h rd1=%h rw=%b addr=%h din=%h exp all zero",
               name, gnt1, gnt0, rvalid1, rvalid0, rdata0, rdata1,
               mem_rw_select, mem_address, mem_data_in);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    req0 = 1; we0 = 1; addr0 = 9'h0AB; wdata0 = 8'hEE;
    req1 = 1; we1 = 1; addr1 = 9'h0CD; wdata1 = 8'hDD;
    #3;
    check_all_zero("reset_outputs");
    do_reset();
    idle("reset_idle");
  endtask

  task automatic test_write_read();
    do_reset();
    step(1, 1, 0, 9'h005, 8'hA5, 0, 0, 0, '0, '0, 2'b01, "t1_write");
    step(1, 0, 0, 9'h005, 8'h00, 0, 0, 0, '0, '0, 2'b01, "t1_read");
    idle("t1_return");
    checks++;
    if (rdata0 !== 8'hA5) begin
      failures++;
      $display("FAIL t1_rdata_hold: got %h exp a5", rdata0);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    step(0, 0, 0, '0, '0, 1, 1, 0, 9'h010, 8'h11, 2'b10, "t2_pre_w1");
    step(1, 1, 0, 9'h020, 8'h22, 0, 0, 0, '0, '0, 2'b01, "t2_pre_w0");
    do_reset();
    step(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t2_rr0");
    step(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b10, "t2_rr1");
    step(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t2_rr2");
    step(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b10, "t2_rr3");
    idle("t2_return");
  endtask

  task automatic test_lock();
    do_reset();
    step(1, 0, 1, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t3_lock_a");
    step(1, 0, 1, 9'h005, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t3_lock_b");
    step(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t3_lock_c");
    step(1, 0, 0, 9'h005, '0, 1, 0, 0, 9'h010, '0, 2'b10, "t3_release");
    idle("t3_return");
  endtask

  task automatic test_ordering_boundary();
    do_reset();
    step(1, 1, 0, 9'h000, 8'h77, 0, 0, 0, '0, '0, 2'b01, "t4_w000");
    step(0, 0, 0, '0, '0, 1, 1, 0, 9'h1FF, 8'h3C, 2'b10, "t4_w1ff");
    step(1, 0, 0, 9'h1FF, '0, 0, 0, 0, '0, '0, 2'b01, "t4_r1ff");
    step(1, 0, 0, 9'h000, '0, 0, 0, 0, '0, '0, 2'b01, "t4_r000");
    idle("t4_return");
  endtask

  task automatic test_idle();
    int w_before;
    do_reset();
    step(1, 0, 0, 9'h005, '0, 1, 0, 0, 9'h010, '0, 2'b01, "t5_first");
    w_before = ram_writes;
    for (int i = 0; i < 5; i++) idle("t5_idle");
    checks++;
    if (ram_writes !== w_before) begin
      failures++;
      $display("FAIL t5_no_write: got %0d ram writes exp 0", ram_writes - w_before);
    end
    step(1, 0, 0, 9'h005, '0, 1, 0, 0, 9'h010, '0, 2'b10, "t5_ptr_kept");
    step(1, 0, 0, 9'h005, '0, 0, 0, 0, '0, '0, 2'b01, "t5_rb005");
    step(0, 0, 0, '0, '0, 1, 0, 0, 9'h1FF, '0, 2'b10, "t5_rb1ff");
    idle("t5_return");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    step(1, 0, 0, 9'h1FF, '0, 0, 0, 0, '0, '0, 2'b01, "t6_read");
    req0 = 1; we0 = 1; addr0 = 9'h055; wdata0 = 8'h99;
    req1 = 1; we1 = 0; addr1 = 9'h066;
    #2;
    rst_n = 0;
    #1;
    check_all_zero("t6_async_reset");
    drop_inputs();
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle("t6_no_rvalid");
    step(1, 0, 0, 9'h000, '0, 1, 0, 0, 9'h1FF, '0, 2'b01, "t6_first_gnt");
    idle("t6_return");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_ordering_boundary();
    test_idle();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
